// File: rtl/multicycle_sequencer_pkg.sv
// Shared types for the multi-cycle stage sequencer.
// State encoding and small constants used by the top and its helpers.
package multicycle_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_RUN    = 2'd1,
        SEQ_HALTED = 2'd2
    } seq_state_t;

    localparam int SEQ_MIN_STAGES = 2;

endpackage

// File: rtl/multicycle_sequencer_watchdog.sv
// Per-stage watchdog: counts active cycles since stage entry.
// Entry cycle counts as 1; expire flags the TMO_MAX-th active cycle.
module stage_watchdog #(
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TMO_MAX);
    localparam logic [TMO_W-1:0] ONE   = TMO_W'(1);

    logic [TMO_W-1:0] cnt;

    // Load 1 on the edge entering a stage, then count up and hold at the limit
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= ONE;
        end else if (enable && cnt != LIMIT) begin
            cnt <= cnt + ONE;
        end
    end

    assign expire = (TMO_MAX != 0) && enable && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Stage sequencer for the multi-cycle core: one-hot stage enables,
// flush/redirect, stall watchdog, halt and commit/cycle counters.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int NSTAGE  = 4,
    parameter int CNT_W   = 64,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stage_done,
    input  logic [NSTAGE-1:0] stage_bypass,
    input  logic              redirect,
    input  logic              halt,
    output logic [NSTAGE-1:0] stage_valid,
    output logic [NSTAGE-1:0] stage_start,
    output logic              commit,
    output logic              timeout,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam logic [SW-1:0]     LAST  = SW'(NSTAGE - 1);
    localparam logic [SW-1:0]     IONE  = SW'(1);
    localparam logic [NSTAGE-1:0] FIRST = NSTAGE'(1);
    localparam logic [CNT_W-1:0]  CONE  = CNT_W'(1);

    seq_state_t    state;
    logic [SW-1:0] idx;
    logic [SW-1:0] idx_nxt;
    logic          halt_lat;
    logic          run;
    logic          adv;
    logic          last;
    logic          wd_expire;
    logic          abort;
    logic          flush;
    logic          wd_clear;

    assign run     = (state == SEQ_RUN);
    assign adv     = stage_done[idx] | ((idx != '0) & stage_bypass[idx]);
    assign last    = (idx == LAST);
    assign idx_nxt = idx + IONE;
    assign abort   = wd_expire & ~adv;
    assign flush   = redirect | abort;
    assign wd_clear = (state == SEQ_IDLE) | (run & (redirect | adv | abort));

    stage_watchdog #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (run),
        .expire (wd_expire)
    );

    // Sequencer FSM with registered stage enables, pulses and counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= SEQ_IDLE;
            idx         <= '0;
            halt_lat    <= 1'b0;
            stage_valid <= '0;
            stage_start <= '0;
            commit      <= 1'b0;
            timeout     <= 1'b0;
            halted      <= 1'b0;
            cycle_cnt   <= '0;
            instret     <= '0;
            flush_cnt   <= '0;
        end else begin
            commit      <= 1'b0;
            stage_start <= '0;
            unique case (state)
                SEQ_IDLE: begin
                    cycle_cnt <= cycle_cnt + CONE;
                    if (halt) begin
                        state       <= SEQ_HALTED;
                        halted      <= 1'b1;
                        stage_valid <= '0;
                    end else begin
                        state       <= SEQ_RUN;
                        idx         <= '0;
                        stage_valid <= FIRST;
                        stage_start <= FIRST;
                    end
                end
                SEQ_RUN: begin
                    cycle_cnt <= cycle_cnt + CONE;
                    halt_lat  <= halt_lat | halt;
                    if (flush) begin
                        idx         <= '0;
                        stage_valid <= FIRST;
                        stage_start <= FIRST;
                        flush_cnt   <= flush_cnt + CONE;
                        if (abort) begin
                            timeout <= 1'b1;
                        end
                    end else if (adv && last) begin
                        commit  <= 1'b1;
                        instret <= instret + CONE;
                        idx     <= '0;
                        if (halt | halt_lat) begin
                            state       <= SEQ_HALTED;
                            halted      <= 1'b1;
                            stage_valid <= '0;
                        end else begin
                            stage_valid <= FIRST;
                            stage_start <= FIRST;
                        end
                    end else if (adv) begin
                        idx         <= idx_nxt;
                        stage_valid <= FIRST << idx_nxt;
                        stage_start <= FIRST << idx_nxt;
                    end
                end
                SEQ_HALTED: begin
                    stage_valid <= '0;
                    halted      <= 1'b1;
                end
                default: begin
                    state       <= SEQ_IDLE;
                    stage_valid <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (NSTAGE=4, TMO_MAX=8, CNT_W=4).
// Commits are scored against a queue of expected instret values.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] stage_done;
    logic [3:0] stage_bypass;
    logic       redirect;
    logic       halt;
    logic [3:0] stage_valid;
    logic [3:0] stage_start;
    logic       commit;
    logic       timeout;
    logic       halted;
    logic [3:0] cycle_cnt;
    logic [3:0] instret;
    logic [3:0] flush_cnt;

    int         chks = 0;
    int         errs = 0;
    logic [3:0] sb[$];
    logic [3:0] exp_ins;
    logic [3:0] exp_cyc;
    logic [3:0] exp_v;
    logic       m_halt;

    multicycle_sequencer #(
        .NSTAGE  (4),
        .CNT_W   (4),
        .TMO_W   (8),
        .TMO_MAX (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stage_done   (stage_done),
        .stage_bypass (stage_bypass),
        .redirect     (redirect),
        .halt         (halt),
        .stage_valid  (stage_valid),
        .stage_start  (stage_start),
        .commit       (commit),
        .timeout      (timeout),
        .halted       (halted),
        .cycle_cnt    (cycle_cnt),
        .instret      (instret),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        chks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            exp_cyc = '0;
            m_halt  = 1'b0;
        end else if (!m_halt) begin
            exp_cyc = exp_cyc + 4'd1;
        end
        #1;
    endtask

    task automatic expect_commit();
        exp_ins = exp_ins + 4'd1;
        sb.push_back(exp_ins);
    endtask

    // Score every commit pulse against the oldest expected instret
    always @(negedge clk) begin
        if (commit === 1'b1) begin
            chks++;
            assert (sb.size() != 0) else begin
                errs++;
                $error("FAIL commit_unexpected observed=1 expected=0");
            end
            if (sb.size() != 0) begin
                exp_v = sb.pop_front();
                chks++;
                assert (instret === exp_v) else begin
                    errs++;
                    $error("FAIL sb_instret observed=%0h expected=%0h",
                           instret, exp_v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst = 1'b0;
        stage_done = '0;
        stage_bypass = '0;
        redirect = 1'b0;
        halt = 1'b0;
        exp_ins = '0;
        exp_cyc = '0;
        m_halt = 1'b0;
        tick();
        tick();
        check("rst_valid", stage_valid, 4'b0000);
        check("rst_start", stage_start, 4'b0000);
        check("rst_commit", commit, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_cycle", cycle_cnt, 4'd0);
        check("rst_instret", instret, 4'd0);
        check("rst_flush", flush_cnt, 4'd0);

        // basic walk with all done bits held
        rst = 1'b1;
        stage_done = 4'b1111;
        tick();
        check("walk_v0", stage_valid, 4'b0001);
        check("walk_s0", stage_start, 4'b0001);
        check("walk_cyc", cycle_cnt, exp_cyc);
        tick();
        check("walk_v1", stage_valid, 4'b0010);
        check("walk_s1", stage_start, 4'b0010);
        tick();
        check("walk_v2", stage_valid, 4'b0100);
        tick();
        check("walk_v3", stage_valid, 4'b1000);
        expect_commit();
        tick();
        check("walk_commit", commit, 1'b1);
        check("walk_start0", stage_start, 4'b0001);
        check("walk_valid0", stage_valid, 4'b0001);
        check("walk_instret", instret, 4'd1);

        // bypass[0] ignored, bypass[2] skips stage 2 in one cycle
        stage_done = '0;
        stage_bypass = 4'b0001;
        tick();
        check("byp0_hold", stage_valid, 4'b0001);
        check("byp0_nostart", stage_start, 4'b0000);
        stage_bypass = '0;
        stage_done = 4'b0001;
        tick();
        check("byp_v1", stage_valid, 4'b0010);
        stage_done = 4'b0010;
        tick();
        check("byp_v2", stage_valid, 4'b0100);
        stage_done = '0;
        stage_bypass = 4'b0100;
        tick();
        check("byp_v3", stage_valid, 4'b1000);
        check("byp_s3", stage_start, 4'b1000);
        stage_bypass = '0;
        stage_done = 4'b1000;
        expect_commit();
        tick();
        check("byp_commit", commit, 1'b1);

        // redirect in stage 2
        stage_done = 4'b0001;
        tick();
        stage_done = 4'b0010;
        tick();
        check("rdr_in2", stage_valid, 4'b0100);
        stage_done = '0;
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        check("rdr_valid", stage_valid, 4'b0001);
        check("rdr_start", stage_start, 4'b0001);
        check("rdr_commit", commit, 1'b0);
        check("rdr_flush", flush_cnt, 4'd1);
        check("rdr_instret", instret, 4'd2);

        // redirect beats done in the last stage
        stage_done = 4'b0001;
        tick();
        stage_done = 4'b0010;
        tick();
        stage_done = 4'b0100;
        tick();
        check("rdr3_in3", stage_valid, 4'b1000);
        stage_done = 4'b1000;
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        stage_done = '0;
        check("rdr3_commit", commit, 1'b0);
        check("rdr3_valid", stage_valid, 4'b0001);
        check("rdr3_flush", flush_cnt, 4'd2);
        check("rdr3_instret", instret, 4'd2);

        // done on the 8th active cycle wins over the watchdog
        stage_done = 4'b0001;
        tick();
        stage_done = '0;
        repeat (7) tick();
        check("wd8_still1", stage_valid, 4'b0010);
        stage_done = 4'b0010;
        tick();
        check("wd8_adv", stage_valid, 4'b0100);
        check("wd8_timeout", timeout, 1'b0);
        check("wd8_flush", flush_cnt, 4'd2);
        stage_done = 4'b0100;
        tick();
        stage_done = 4'b1000;
        expect_commit();
        tick();
        check("wd8_commit", commit, 1'b1);

        // watchdog abort in stage 1
        stage_done = 4'b0001;
        tick();
        stage_done = '0;
        repeat (7) tick();
        check("wd_pre", stage_valid, 4'b0010);
        check("wd_pre_to", timeout, 1'b0);
        tick();
        check("wd_valid", stage_valid, 4'b0001);
        check("wd_start", stage_start, 4'b0001);
        check("wd_timeout", timeout, 1'b1);
        check("wd_flush", flush_cnt, 4'd3);
        check("wd_commit", commit, 1'b0);
        tick();
        check("wd_sticky", timeout, 1'b1);

        // halt pulsed in stage 1
        stage_done = 4'b0001;
        tick();
        stage_done = '0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("hlt_notyet", halted, 1'b0);
        check("hlt_in1", stage_valid, 4'b0010);
        stage_done = 4'b0010;
        tick();
        stage_done = 4'b0100;
        tick();
        stage_done = 4'b1000;
        expect_commit();
        tick();
        m_halt = 1'b1;
        stage_done = '0;
        check("hlt_commit", commit, 1'b1);
        check("hlt_halted", halted, 1'b1);
        check("hlt_valid", stage_valid, 4'b0000);
        check("hlt_start", stage_start, 4'b0000);
        redirect = 1'b1;
        repeat (3) tick();
        redirect = 1'b0;
        check("hlt_frozen", cycle_cnt, exp_cyc);
        check("hlt_flush", flush_cnt, 4'd3);
        check("hlt_instret", instret, 4'd4);
        check("hlt_valid2", stage_valid, 4'b0000);
        rst = 1'b0;
        tick();
        check("hrst_valid", stage_valid, 4'b0000);
        check("hrst_halted", halted, 1'b0);
        check("hrst_timeout", timeout, 1'b0);
        check("hrst_cycle", cycle_cnt, 4'd0);
        check("hrst_instret", instret, 4'd0);
        check("hrst_flush", flush_cnt, 4'd0);

        // sixteen commits wrap the 4-bit instret
        exp_ins = '0;
        rst = 1'b1;
        stage_done = 4'b1111;
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            tick();
            tick();
            expect_commit();
            tick();
        end
        check("wrap_instret", instret, exp_ins);
        check("wrap_zero", instret, 4'd0);
        check("wrap_cycle", cycle_cnt, exp_cyc);

        // reset mid stage 2 aborts without commit
        tick();
        tick();
        check("mid_in2", stage_valid, 4'b0100);
        rst = 1'b0;
        stage_done = '0;
        tick();
        check("mid_valid", stage_valid, 4'b0000);
        check("mid_commit", commit, 1'b0);
        check("mid_instret", instret, 4'd0);
        check("mid_cycle", cycle_cnt, 4'd0);

        // halt seen in IDLE goes straight to HALTED
        rst = 1'b1;
        halt = 1'b1;
        tick();
        m_halt = 1'b1;
        halt = 1'b0;
        check("ihlt_halted", halted, 1'b1);
        check("ihlt_valid", stage_valid, 4'b0000);
        tick();
        check("ihlt_cycle", cycle_cnt, exp_cyc);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", chks, errs);
        $finish;
    end

endmodule
